// File: rtl/move_list_reader_pkg.sv
// Shared move-RAM definitions: board geometry, RAM word packing and the
// reader FSM encoding.
package move_list_reader_pkg;

  localparam int PIECE_BITS        = 4;
  localparam int MAX_POSITIONS_DEF = 256;
  localparam int BOARD_BITS        = PIECE_BITS * 64;

  // RAM word layout from MSB to LSB: en_passant, castle, to_move, board.
  localparam int RAM_BOARD_LSB   = 0;
  localparam int RAM_TOMOVE_BIT  = BOARD_BITS;
  localparam int RAM_CASTLE_LSB  = BOARD_BITS + 1;
  localparam int RAM_EP_LSB      = BOARD_BITS + 5;
  localparam int RAM_WIDTH       = BOARD_BITS + 9;

  typedef struct packed {
    logic [3:0]            en_passant_col;
    logic [3:0]            castle_mask;
    logic                  white_to_move;
    logic [BOARD_BITS-1:0] board;
  } ram_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_LATCH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_DRAIN = 3'd5
  } mlr_state_t;

  // An empty list has no last element, so cnt-1 is never formed for cnt==0.
  function automatic logic is_last_idx(input int unsigned n, input int unsigned cnt);
    return (cnt != 0) && (n == cnt - 1);
  endfunction

endpackage

// File: rtl/move_list_reader.sv
// Walks a completed move list out of the generator RAM and streams each
// position downstream, then releases the generator for the next list.
module move_list_reader
  import move_list_reader_pkg::*;
#(
  parameter int PIECE_WIDTH        = PIECE_BITS,
  parameter int SIDE_WIDTH         = PIECE_WIDTH * 8,
  parameter int BOARD_WIDTH        = SIDE_WIDTH * 8,
  parameter int MAX_POSITIONS      = MAX_POSITIONS_DEF,
  parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS)
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          moves_ready,
  input  logic [MAX_POSITIONS_LOG2-1:0] move_count,
  input  logic [BOARD_WIDTH-1:0]        board_in,
  input  logic                          white_to_move_in,
  input  logic [3:0]                    castle_mask_in,
  input  logic [3:0]                    en_passant_col_in,
  output logic [MAX_POSITIONS_LOG2-1:0] move_index,
  output logic                          clear_moves,
  input  logic                          abort,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BOARD_WIDTH-1:0]        out_board,
  output logic                          out_white_to_move,
  output logic [3:0]                    out_castle_mask,
  output logic [3:0]                    out_en_passant_col,
  output logic [MAX_POSITIONS_LOG2-1:0] out_index,
  output logic                          out_last,
  output logic                          list_done,
  output logic                          list_empty
);

  mlr_state_t                    r_state;
  logic [MAX_POSITIONS_LOG2-1:0] r_n;
  logic [MAX_POSITIONS_LOG2-1:0] r_cnt;
  logic                          r_clear;
  logic                          r_valid;
  logic [BOARD_WIDTH-1:0]        r_board;
  logic                          r_wtm;
  logic [3:0]                    r_castle;
  logic [3:0]                    r_ep;
  logic [MAX_POSITIONS_LOG2-1:0] r_oidx;
  logic                          r_last;
  logic                          r_done;
  logic                          r_empty;

  logic [MAX_POSITIONS_LOG2-1:0] w_n_next;
  logic                          w_last;

  assign w_n_next = r_n + 1'b1;
  assign w_last   = is_last_idx(32'(r_n), 32'(r_cnt));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_n      <= '0;
      r_cnt    <= '0;
      r_clear  <= 1'b0;
      r_valid  <= 1'b0;
      r_board  <= '0;
      r_wtm    <= 1'b0;
      r_castle <= '0;
      r_ep     <= '0;
      r_oidx   <= '0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
      r_empty  <= 1'b0;
    end else begin
      r_clear <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_n <= '0;
          if (moves_ready) begin
            r_cnt   <= move_count;
            r_empty <= (move_count == '0);
            r_state <= (move_count == '0) ? ST_CLEAR : ST_ADDR;
          end
        end
        // move_index is stable this cycle; the RAM answers during LATCH.
        ST_ADDR: begin
          if (abort) begin
            r_valid <= 1'b0;
            r_state <= ST_CLEAR;
          end else begin
            r_state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (abort) begin
            r_valid <= 1'b0;
            r_state <= ST_CLEAR;
          end else begin
            r_board  <= board_in;
            r_wtm    <= white_to_move_in;
            r_castle <= castle_mask_in;
            r_ep     <= en_passant_col_in;
            r_oidx   <= r_n;
            r_last   <= w_last;
            r_valid  <= 1'b1;
            r_state  <= ST_HOLD;
          end
        end
        // Abort wins over a same-cycle handshake: nothing further is shown.
        ST_HOLD: begin
          if (abort) begin
            r_valid <= 1'b0;
            r_state <= ST_CLEAR;
          end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
            if (r_last) begin
              r_state <= ST_CLEAR;
            end else begin
              r_n     <= w_n_next;
              r_state <= ST_ADDR;
            end
          end
        end
        ST_CLEAR: begin
          r_clear <= 1'b1;
          r_done  <= 1'b1;
          r_state <= ST_DRAIN;
        end
        // Wait for the generator to drop moves_ready so a stale list is not reread.
        ST_DRAIN: begin
          if (!moves_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign move_index         = r_n;
  assign clear_moves        = r_clear;
  assign out_valid          = r_valid;
  assign out_board          = r_board;
  assign out_white_to_move  = r_wtm;
  assign out_castle_mask    = r_castle;
  assign out_en_passant_col = r_ep;
  assign out_index          = r_oidx;
  assign out_last           = r_last;
  assign list_done          = r_done;
  assign list_empty         = r_empty;

endmodule

// File: tb/tb_move_list_reader.sv
// Randomized bench for move_list_reader: RAM and generator models plus a
// cycle-schedule scoreboard of every presented and accepted position.
module tb_move_list_reader;

  localparam int BW   = 256;
  localparam int IW   = 8;
  localparam int MAXP = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          moves_ready;
  logic [IW-1:0] move_count;
  logic [BW-1:0] board_in;
  logic          white_to_move_in;
  logic [3:0]    castle_mask_in;
  logic [3:0]    en_passant_col_in;
  logic [IW-1:0] move_index;
  logic          clear_moves;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_board;
  logic          out_white_to_move;
  logic [3:0]    out_castle_mask;
  logic [3:0]    out_en_passant_col;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          list_done;
  logic          list_empty;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] mem_board [MAXP];
  logic          mem_wtm   [MAXP];
  logic [3:0]    mem_cm    [MAXP];
  logic [3:0]    mem_ep    [MAXP];

  move_list_reader dut (
    .clk(clk), .reset(reset), .moves_ready(moves_ready), .move_count(move_count),
    .board_in(board_in), .white_to_move_in(white_to_move_in),
    .castle_mask_in(castle_mask_in), .en_passant_col_in(en_passant_col_in),
    .move_index(move_index), .clear_moves(clear_moves), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_board(out_board),
    .out_white_to_move(out_white_to_move), .out_castle_mask(out_castle_mask),
    .out_en_passant_col(out_en_passant_col), .out_index(out_index),
    .out_last(out_last), .list_done(list_done), .list_empty(list_empty)
  );

  always #5 clk = ~clk;

  // One-cycle read latency RAM.
  always @(posedge clk) begin
    board_in          <= mem_board[move_index];
    white_to_move_in  <= mem_wtm[move_index];
    castle_mask_in    <= mem_cm[move_index];
    en_passant_col_in <= mem_ep[move_index];
  end

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Streams one list. Expected schedule: first position 3 cycles after the
  // moves_ready cycle, each next one 3 cycles after the accepting cycle, and
  // clear/done 2 cycles after the last accept, abort, or empty-list start.
  task automatic run_list(input int cnt, input int rdy_pct, input int abort_idx,
                          input int extra, input int stall0);
    int cyc, ref_cyc, exp_idx, n_clr, n_done, drop_at, idle_n, v0;
    logic pv, pr, pa, stopped, finished;
    logic [IW-1:0] pidx;
    logic [BW-1:0] pboard;
    for (int i = 0; i < cnt; i++) begin
      for (int w = 0; w < BW / 32; w++) mem_board[i][w*32 +: 32] = $urandom;
      mem_wtm[i] = 1'($urandom);
      mem_cm[i]  = 4'($urandom);
      mem_ep[i]  = 4'($urandom);
    end
    moves_ready = 1'b1;
    move_count  = IW'(cnt);
    abort       = 1'b0;
    out_ready   = ($urandom_range(0, 99) < rdy_pct);
    ref_cyc = 0; exp_idx = 0; n_clr = 0; n_done = 0; drop_at = -1; idle_n = 0; v0 = 0;
    stopped = (cnt == 0);
    finished = 1'b0;
    for (cyc = 1; cyc <= 400 && !finished; cyc++) begin
      pv = out_valid; pr = out_ready; pa = abort; pidx = out_index; pboard = out_board;
      @(posedge clk); #1;
      if (pv && !stopped) begin
        if (pa) begin
          stopped = 1'b1;
          ref_cyc = cyc - 1;
          chk("abort_drop", BW'(out_valid), BW'(0));
        end else if (pr) begin
          exp_idx++;
          ref_cyc = cyc - 1;
          if (exp_idx == cnt) stopped = 1'b1;
        end else begin
          chk("hold_valid", BW'(out_valid), BW'(1));
          chk("hold_board", out_board, pboard);
          chk("hold_index", BW'(out_index), BW'(pidx));
          chk("hold_addr", BW'(move_index), BW'(pidx));
        end
      end
      if (stopped) chk("no_valid_after_end", BW'(out_valid), BW'(0));
      else if (out_valid && !pv) begin
        chk("gap", BW'(cyc - ref_cyc), BW'(3));
        chk("index", BW'(out_index), BW'(exp_idx));
        chk("board", out_board, mem_board[exp_idx]);
        chk("meta", BW'({out_white_to_move, out_castle_mask, out_en_passant_col}),
            BW'({mem_wtm[exp_idx], mem_cm[exp_idx], mem_ep[exp_idx]}));
        chk("last", BW'(out_last), BW'(exp_idx == cnt - 1));
      end
      if (clear_moves) begin
        n_clr++;
        chk("clear_time", BW'(cyc), BW'(ref_cyc + 2));
        if (drop_at < 0) drop_at = cyc + 1 + extra;
      end
      if (list_done) begin
        n_done++;
        chk("done_time", BW'(cyc), BW'(ref_cyc + 2));
      end
      if (drop_at >= 0 && cyc >= drop_at) moves_ready = 1'b0;
      if (!moves_ready) begin
        idle_n++;
        if (idle_n >= 4) finished = 1'b1;
      end
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      if (out_valid && out_index == 0 && v0 < stall0) begin
        out_ready = 1'b0;
        v0++;
      end
      abort = !stopped && out_valid && abort_idx >= 0 && (32'(out_index) == abort_idx);
    end
    abort = 1'b0;
    if (!finished) chk("timeout", BW'(1), BW'(0));
    chk("clear_count", BW'(n_clr), BW'(1));
    chk("done_count", BW'(n_done), BW'(1));
    chk("list_empty", BW'(list_empty), BW'(cnt == 0));
    if (abort_idx < 0 || abort_idx >= cnt) chk("accepted", BW'(exp_idx), BW'(cnt));
  endtask

  initial begin
    int c, a;
    for (int i = 0; i < MAXP; i++) begin
      mem_board[i] = '0; mem_wtm[i] = 1'b0; mem_cm[i] = '0; mem_ep[i] = '0;
    end
    reset = 1'b1; moves_ready = 1'b0; move_count = '0; abort = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", BW'(out_valid), BW'(0));
    chk("rst_clear", BW'(clear_moves), BW'(0));
    chk("rst_done", BW'(list_done), BW'(0));
    chk("rst_empty", BW'(list_empty), BW'(0));
    chk("rst_addr", BW'(move_index), BW'(0));
    chk("rst_board", out_board, BW'(0));
    chk("rst_meta", BW'({out_index, out_last, out_white_to_move, out_castle_mask, out_en_passant_col}), BW'(0));
    reset = 1'b0;

    run_list(3, 100, -1, 0, 0);   // basic stream
    run_list(2, 100, -1, 0, 5);   // backpressure on index 0
    run_list(0, 100, -1, 0, 0);   // empty list
    run_list(5, 100, 1, 0, 0);    // abort on index 1
    run_list(5, 50, 2, 1, 0);
    run_list(0, 100, -1, 1, 0);   // re-arm with moves_ready lingering
    run_list(1, 100, -1, 1, 0);
    for (int k = 0; k < 25; k++) begin
      c = $urandom_range(0, 12);
      a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : -1;
      run_list(c, $urandom_range(30, 100), a, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset while a position is held.
    mem_board[0] = {8{32'hA5A5_0F0F}};
    moves_ready = 1'b1; move_count = IW'(3); out_ready = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_valid", BW'(out_valid), BW'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_valid", BW'(out_valid), BW'(0));
    chk("mid_reset_clear", BW'(clear_moves), BW'(0));
    chk("mid_reset_addr", BW'(move_index), BW'(0));
    reset = 1'b0; moves_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post_reset_quiet", BW'({clear_moves, list_done, out_valid}), BW'(0));
    end
    run_list(2, 100, -1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
